// File: rtl/display_edit_ctrl.sv
// display_edit_ctrl: front-panel edit sequencer for the RTC display.
// Selects between live RTC time/date and user-edited values, times out idle
// edits on the 1 Hz tick, and hands confirmed edits to the RTC write path
// through a req/ack handshake with a bounded wait.
module display_edit_ctrl #(
  parameter int TIMEOUT_S = 30,
  parameter int ACK_WAIT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       prog_time,
  input  logic       prog_date,
  input  logic       key_act,
  input  logic       accept,
  input  logic       cancel,
  input  logic       wr_ack,
  output logic [1:0] seleccion,
  output logic       editing,
  output logic       wr_req,
  output logic       wr_target,
  output logic       wr_err
);

  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam int AW = $clog2(ACK_WAIT + 1);

  typedef enum logic [1:0] {SHOW, EDIT_TIME, EDIT_DATE, WRITE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [AW-1:0] ack_cnt, ack_nxt;
  logic          tgt_nxt;
  logic          err_nxt;

  // Mux select for a given state; WRITE keeps showing the field being written.
  function automatic logic [1:0] sel_of(input state_t s, input logic tgt);
    unique case (s)
      EDIT_TIME: sel_of = 2'b01;
      EDIT_DATE: sel_of = 2'b10;
      WRITE:     sel_of = tgt ? 2'b10 : 2'b01;
      default:   sel_of = 2'b00;
    endcase
  endfunction

  // Next state, counters and output intent.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    idle_nxt  = idle_cnt;
    ack_nxt   = ack_cnt;
    tgt_nxt   = wr_target;
    err_nxt   = 1'b0;
    unique case (state)
      SHOW: begin
        idle_nxt = '0;
        ack_nxt  = '0;
        tgt_nxt  = 1'b0;
        if (prog_time)      state_nxt = EDIT_TIME;
        else if (prog_date) state_nxt = EDIT_DATE;
      end
      EDIT_TIME, EDIT_DATE: begin
        ack_nxt = '0;
        if (cancel) begin
          state_nxt = SHOW;
          idle_nxt  = '0;
        end else if (accept) begin
          state_nxt = WRITE;
          idle_nxt  = '0;
          tgt_nxt   = (state == EDIT_DATE);
        end else if (tick_1hz && idle_cnt == IW'(TIMEOUT_S)) begin
          state_nxt = SHOW;
          idle_nxt  = '0;
        end else if (key_act) begin
          idle_nxt = '0;
        end else if (tick_1hz && idle_cnt < IW'(TIMEOUT_S)) begin
          idle_nxt = idle_cnt + IW'(1);
        end
      end
      WRITE: begin
        // Ack on the expiry cycle counts as success, so it is tested first.
        if (wr_ack) begin
          state_nxt = SHOW;
          ack_nxt   = '0;
          tgt_nxt   = 1'b0;
        end else if (ack_cnt == AW'(ACK_WAIT - 1)) begin
          state_nxt = SHOW;
          ack_nxt   = '0;
          tgt_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          ack_nxt = ack_cnt + AW'(1);
        end
      end
      default: state_nxt = SHOW;
    endcase
  end

  // State, counters and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SHOW;
      idle_cnt  <= '0;
      ack_cnt   <= '0;
      seleccion <= 2'b00;
      editing   <= 1'b0;
      wr_req    <= 1'b0;
      wr_target <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state     <= state_nxt;
      idle_cnt  <= idle_nxt;
      ack_cnt   <= ack_nxt;
      seleccion <= sel_of(state_nxt, tgt_nxt);
      editing   <= (state_nxt == EDIT_TIME) || (state_nxt == EDIT_DATE);
      wr_req    <= (state_nxt == WRITE);
      wr_target <= tgt_nxt;
      wr_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_display_edit_ctrl.sv
// Self-checking bench for display_edit_ctrl with TIMEOUT_S=3, ACK_WAIT=4.
// Expected output words are pushed to a queue with each driven cycle and
// popped for comparison one clock later.
module tb_display_edit_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz, prog_time, prog_date, key_act, accept, cancel, wr_ack;
  logic [1:0] seleccion;
  logic       editing, wr_req, wr_target, wr_err;

  int n_checks = 0;
  int n_errors = 0;

  display_edit_ctrl #(.TIMEOUT_S(3), .ACK_WAIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .prog_time (prog_time),
    .prog_date (prog_date),
    .key_act   (key_act),
    .accept    (accept),
    .cancel    (cancel),
    .wr_ack    (wr_ack),
    .seleccion (seleccion),
    .editing   (editing),
    .wr_req    (wr_req),
    .wr_target (wr_target),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  // Input bits: {prog_time, prog_date, key_act, accept, cancel, tick, wr_ack}
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] PT = 7'b1000000;
  localparam logic [6:0] PD = 7'b0100000;
  localparam logic [6:0] KA = 7'b0010000;
  localparam logic [6:0] AC = 7'b0001000;
  localparam logic [6:0] CA = 7'b0000100;
  localparam logic [6:0] TK = 7'b0000010;
  localparam logic [6:0] WA = 7'b0000001;

  // Output word: {seleccion[1:0], editing, wr_req, wr_target, wr_err}
  localparam logic [5:0] O_SHOW = 6'b00_0000;
  localparam logic [5:0] O_ET   = 6'b01_1000;
  localparam logic [5:0] O_ED   = 6'b10_1000;
  localparam logic [5:0] O_WT   = 6'b01_0100;
  localparam logic [5:0] O_WD   = 6'b10_0110;
  localparam logic [5:0] O_ERR  = 6'b00_0001;

  typedef struct {
    logic [6:0] in;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] sb[$];

  function automatic vec_t mk(input logic [6:0] in, input logic [5:0] exp,
                              input string name);
    vec_t v;
    v.in   = in;
    v.exp  = exp;
    v.name = name;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {seleccion, editing, wr_req, wr_target, wr_err};
  endfunction

  task automatic check(input string name, input logic [5:0] act,
                       input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {sel,edit,req,tgt,err}=%b, want %b", name, act, exp);
    end
  endtask

  // Drive one cycle of pulses, then compare outputs just after the edge.
  task automatic cycle(input logic [6:0] in, input logic [5:0] exp,
                       input string name);
    logic [5:0] want;
    {prog_time, prog_date, key_act, accept, cancel, tick_1hz, wr_ack} = in;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    {prog_time, prog_date, key_act, accept, cancel, tick_1hz, wr_ack} = NO;
    want = sb.pop_front();
    check(name, outs(), want);
  endtask

  initial begin
    reset = 1'b0;
    {prog_time, prog_date, key_act, accept, cancel, tick_1hz, wr_ack} = NO;
    #12;
    check("reset_values", outs(), O_SHOW);
    @(negedge clk);
    reset = 1'b1;

    // Table of single-cycle vectors, applied in order from reset.
    tbl.push_back(mk(NO,      O_SHOW, "idle_show"));
    tbl.push_back(mk(AC,      O_SHOW, "accept_in_show_ignored"));
    tbl.push_back(mk(CA | KA, O_SHOW, "cancel_key_in_show_ignored"));
    tbl.push_back(mk(PT,      O_ET,   "prog_time_enters"));
    tbl.push_back(mk(PD,      O_ET,   "prog_date_in_edit_time_ignored"));
    tbl.push_back(mk(CA,      O_SHOW, "cancel_time"));
    tbl.push_back(mk(PT | PD, O_ET,   "time_wins_over_date"));
    tbl.push_back(mk(CA,      O_SHOW, "cancel_time_2"));
    tbl.push_back(mk(PD,      O_ED,   "prog_date_enters"));
    tbl.push_back(mk(CA | AC, O_SHOW, "cancel_beats_accept"));
    tbl.push_back(mk(PD,      O_ED,   "prog_date_again"));
    tbl.push_back(mk(AC,      O_WD,   "accept_date_write"));
    tbl.push_back(mk(NO,      O_WD,   "write_date_wait1"));
    tbl.push_back(mk(KA | CA, O_WD,   "write_ignores_buttons"));
    tbl.push_back(mk(WA,      O_SHOW, "ack_after_3"));
    tbl.push_back(mk(PT,      O_ET,   "prog_time_again"));
    tbl.push_back(mk(AC | PD, O_WT,   "accept_time_write"));
    tbl.push_back(mk(CA,      O_WT,   "write_ignores_cancel"));
    tbl.push_back(mk(WA,      O_SHOW, "ack_time"));
    tbl.push_back(mk(PD,      O_ED,   "prog_date_min"));
    tbl.push_back(mk(AC,      O_WD,   "accept_min"));
    tbl.push_back(mk(WA,      O_SHOW, "ack_min_dwell"));
    foreach (tbl[i]) cycle(tbl[i].in, tbl[i].exp, tbl[i].name);

    // Idle timeout: key_act after tick 2, then 4 ticks back to SHOW.
    // A key_act coinciding with a tick also clears the timer.
    cycle(PT,      O_ET,   "to_enter");
    cycle(TK,      O_ET,   "to_tick1");
    cycle(NO,      O_ET,   "to_gap");
    cycle(TK,      O_ET,   "to_tick2");
    cycle(KA,      O_ET,   "to_key");
    cycle(TK,      O_ET,   "to_after_key_1");
    cycle(TK,      O_ET,   "to_after_key_2");
    cycle(KA | TK, O_ET,   "to_key_tick_clear");
    cycle(TK,      O_ET,   "to_post_clear_1");
    cycle(TK,      O_ET,   "to_post_clear_2");
    cycle(NO,      O_ET,   "to_gap2");
    cycle(TK,      O_ET,   "to_post_clear_3");
    cycle(TK,      O_SHOW, "to_expire");
    cycle(NO,      O_SHOW, "to_no_write");

    // Ack wait expiry with wr_ack held low.
    cycle(PD, O_ED,   "abort_enter");
    cycle(AC, O_WD,   "abort_accept");
    cycle(NO, O_WD,   "abort_wait1");
    cycle(NO, O_WD,   "abort_wait2");
    cycle(NO, O_WD,   "abort_wait3");
    cycle(NO, O_ERR,  "abort_expire_err");
    cycle(NO, O_SHOW, "abort_err_one_cycle");

    // wr_ack on the expiry cycle is a success.
    cycle(PT, O_ET,   "late_enter");
    cycle(AC, O_WT,   "late_accept");
    cycle(NO, O_WT,   "late_wait1");
    cycle(NO, O_WT,   "late_wait2");
    cycle(NO, O_WT,   "late_wait3");
    cycle(WA, O_SHOW, "late_ack_no_err");
    cycle(NO, O_SHOW, "late_still_no_err");

    // Asynchronous reset while wr_req is high.
    cycle(PT, O_ET, "rst_enter");
    cycle(AC, O_WT, "rst_accept");
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_mid_write", outs(), O_SHOW);
    @(negedge clk);
    check("reset_held", outs(), O_SHOW);
    reset = 1'b1;
    cycle(NO, O_SHOW, "after_release_idle");
    cycle(PT, O_ET,   "after_release_prog_time");
    cycle(CA, O_SHOW, "after_release_cancel");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/display_edit_ctrl.md
# display_edit_ctrl

Controller that drives the 2-bit select of the clock display multiplexer and sequences the user editing flow for the RTC front panel. It chooses between the live RTC time/date and the user-programmed time or date. It times out idle edits and hands confirmed values to the RTC write path through a req/ack handshake. It sits between the front-panel button decoder and the display mux / RTC write controller.

## Interface
Parameters:
- TIMEOUT_S, 30: seconds of no key activity in an edit state before returning to SHOW without writing.
- ACK_WAIT, 255: clock cycles WRITE waits for wr_ack before aborting.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse per second, synchronous to clk.
- prog_time  in  1  one-cycle pulse: enter time edit.
- prog_date  in  1  one-cycle pulse: enter date edit.
- key_act  in  1  one-cycle pulse on any up/down/field key while editing.
- accept  in  1  one-cycle pulse: commit the current edit.
- cancel  in  1  one-cycle pulse: discard the current edit.
- wr_ack  in  1  RTC write controller has latched the data. Level; sampled only in WRITE.
- seleccion  out  2  mux select: 00 RTC time+date, 01 user time + RTC date, 10 RTC time + user date. 11 is never driven.
- editing  out  1  high in EDIT_TIME and EDIT_DATE.
- wr_req  out  1  write request, high only in WRITE.
- wr_target  out  1  0 = time block, 1 = date block. Valid while wr_req is high.
- wr_err  out  1  one-cycle pulse when the ACK_WAIT window expires.

## Operation
- States: SHOW, EDIT_TIME, EDIT_DATE, WRITE. All outputs are registered and decoded from state.
- Reset values: state SHOW, seleccion 00, editing 0, wr_req 0, wr_target 0, wr_err 0, both counters 0.
- SHOW:
  - prog_time goes to EDIT_TIME; prog_date goes to EDIT_DATE.
  - If both pulse in the same cycle, time wins.
  - accept, cancel and key_act are ignored.
- EDIT_TIME (seleccion 01) and EDIT_DATE (seleccion 10). Priority within a cycle: cancel > accept > timeout > everything else.
  - cancel goes to SHOW.
  - accept goes to WRITE, with wr_target 0 from EDIT_TIME and 1 from EDIT_DATE.
  - prog_time and prog_date are ignored, so the other edit cannot be entered without leaving first.
- Idle timer (width ceil(log2(TIMEOUT_S+1))):
  - Cleared on entry to an edit state and on any key_act.
  - Increments on tick_1hz otherwise; if key_act and tick_1hz coincide, clear wins.
  - When the timer equals TIMEOUT_S and tick_1hz arrives, go to SHOW without a write.
  - The timer saturates and never wraps.
- WRITE:
  - seleccion holds the value of the originating edit state so the display does not glitch.
  - wr_req is high; all button inputs are ignored.
  - wr_ack high goes to SHOW; wr_req drops on the same edge.
- Ack timer (width ceil(log2(ACK_WAIT+1))):
  - Cleared on entry to WRITE; counts clocks while in WRITE.
  - If the count reaches ACK_WAIT with wr_ack still low, go to SHOW and pulse wr_err for one cycle.
  - If wr_ack arrives in the same cycle as expiry, it is a success and wr_err stays 0.
- Reset asserted mid-edit or mid-write returns immediately (asynchronously) to the reset values; no partial write request remains.

## Timing
- A button pulse sampled at edge N gives the new state, seleccion and editing at edge N (visible after N). That is one clock of latency from pulse to output.
- accept at edge N: wr_req high from N. If wr_ack is high at edge N+k, wr_req is low and seleccion 00 after edge N+k.
  - The minimum WRITE dwell is 1 cycle, when wr_ack is already high at N+1.
- Timeout: with no key_act, SHOW is entered on the edge sampling the (TIMEOUT_S+1)th tick after entry. Tick counting starts at the first tick after the entry edge.
- wr_err is high for exactly the one cycle following the abort edge.
- Reset deassertion is synchronized externally; the first state change can occur on the first clk edge after release.

## Test plan
- Reset, then prog_time: seleccion 00 becomes 01 one cycle later and editing=1. Then cancel: seleccion 00, wr_req never asserted.
- prog_date, then accept, with wr_ack returned 3 cycles later: wr_req=1 and wr_target=1 for 3 cycles, seleccion held at 10 throughout, then 00, wr_err=0.
- TIMEOUT_S=3, enter EDIT_TIME, send key_act after tick 2, then no keys: SHOW after the 4th tick following the key, with no write.
- ACK_WAIT=4, accept with wr_ack held low: SHOW after 4 cycles in WRITE, wr_err pulsed once; repeat with wr_ack on the expiry cycle: wr_err stays 0.
- Simultaneous events:
  - prog_time and prog_date together in SHOW: EDIT_TIME.
  - cancel and accept together in EDIT_DATE: SHOW, no wr_req.
  - prog_date during EDIT_TIME: ignored.
- Assert reset while wr_req=1: all outputs return to reset values immediately without waiting for clk; after release, a new prog_time works normally.
